// File: rtl/qft_measure_argmax.sv
// rtl/qft_measure_argmax.sv - QFT state-vector readout: argmax index, peak probability, total mass (option: QCM_MEAS_NORM_CHECK_EN)
module qft_measure_argmax #(
  parameter  int sample_size    = 32,
  parameter  int complexnum_bit = 24,
  parameter  int frac_bit       = 22,
  parameter  int norm_tol_shift = 10,
  localparam int idx_bit        = $clog2(sample_size),
  localparam int prob_bit       = 2 * complexnum_bit,
  localparam int sum_bit        = prob_bit + idx_bit
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [complexnum_bit-1:0] in_r [sample_size],
  input  logic signed [complexnum_bit-1:0] in_i [sample_size],
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic        [idx_bit-1:0]        max_index,
  output logic        [prob_bit-1:0]       max_prob,
  output logic        [sum_bit-1:0]        prob_sum,
  output logic                             norm_err
);

  typedef enum logic [1:0] {st_idle, st_scan, st_flush, st_done} state_t;

  localparam logic [idx_bit-1:0] last_idx = idx_bit'(sample_size - 1);

  state_t state, state_nxt;

  logic signed [complexnum_bit-1:0] snap_r [sample_size];
  logic signed [complexnum_bit-1:0] snap_i [sample_size];

  logic [idx_bit-1:0]  idx;
  logic [prob_bit-1:0] p_reg;
  logic [idx_bit-1:0]  p_idx;
  logic                p_vld;
  logic [prob_bit-1:0] max_acc;
  logic [idx_bit-1:0]  max_idx_acc;
  logic [sum_bit-1:0]  sum_acc;

  logic signed [prob_bit-1:0] ext_r, ext_i, sq_r, sq_i;
  logic [prob_bit-1:0] p_calc;
  logic [prob_bit-1:0] max_nxt;
  logic [idx_bit-1:0]  max_idx_nxt;
  logic [sum_bit-1:0]  sum_nxt;
  logic                norm_calc;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= st_idle;
    else      state <= state_nxt;
  end

  // FSM next-state: one pass over the vector, one flush cycle, one done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:  if (start) state_nxt = st_scan;
      st_scan:  if (idx == last_idx) state_nxt = st_flush;
      st_flush: state_nxt = st_done;
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  // FSM outputs: busy covers the whole scan including the done cycle
  always_comb begin
    busy = (state != st_idle);
    done = (state == st_done);
  end

  // Snapshot of the QFT output, taken only when a scan is accepted
  always_ff @(posedge clk) begin
    if (state == st_idle && start) begin
      for (int k = 0; k < sample_size; k++) begin
        snap_r[k] <= in_r[k];
        snap_i[k] <= in_i[k];
      end
    end
  end

  // Stage 1: full-precision |a|^2; operands sign-extended so the square is exact
  always_comb begin
    ext_r  = prob_bit'(snap_r[idx]);
    ext_i  = prob_bit'(snap_i[idx]);
    sq_r   = ext_r * ext_r;
    sq_i   = ext_i * ext_i;
    p_calc = $unsigned(sq_r) + $unsigned(sq_i);
  end

  // Stage 2: accumulate and track the strict maximum (ties keep the earlier index)
  always_comb begin
    sum_nxt     = sum_acc;
    max_nxt     = max_acc;
    max_idx_nxt = max_idx_acc;
    if (p_vld) begin
      sum_nxt = sum_acc + sum_bit'(p_reg);
      if (p_reg > max_acc) begin
        max_nxt     = p_reg;
        max_idx_nxt = p_idx;
      end
    end
  end

  // Normalisation check against 1.0 in the squared format
`ifdef QCM_MEAS_NORM_CHECK_EN
  localparam logic [sum_bit-1:0] norm_one = sum_bit'(1) << (2 * frac_bit);
  localparam logic [sum_bit-1:0] norm_tol = sum_bit'(1) << (2 * frac_bit - norm_tol_shift);
  logic [sum_bit-1:0] norm_diff;
  always_comb begin
    norm_diff = (sum_nxt > norm_one) ? (sum_nxt - norm_one) : (norm_one - sum_nxt);
    norm_calc = (norm_diff > norm_tol);
  end
`else
  assign norm_calc = 1'b0;
`endif

  // Datapath registers: counter, pipeline stage and accumulators
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      p_reg       <= '0;
      p_idx       <= '0;
      p_vld       <= 1'b0;
      max_acc     <= '0;
      max_idx_acc <= '0;
      sum_acc     <= '0;
    end else begin
      p_vld <= (state == st_scan);
      if (state == st_idle && start) begin
        idx         <= '0;
        max_acc     <= '0;
        max_idx_acc <= '0;
        sum_acc     <= '0;
      end else begin
        if (state == st_scan) begin
          p_reg <= p_calc;
          p_idx <= idx;
          if (idx != last_idx) idx <= idx + 1'b1;
        end
        max_acc     <= max_nxt;
        max_idx_acc <= max_idx_nxt;
        sum_acc     <= sum_nxt;
      end
    end
  end

  // Result registers load on DONE entry, folding in the last in-flight probability
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_index <= '0;
      max_prob  <= '0;
      prob_sum  <= '0;
      norm_err  <= 1'b0;
    end else if (state == st_flush) begin
      max_index <= max_idx_nxt;
      max_prob  <= max_nxt;
      prob_sum  <= sum_nxt;
      norm_err  <= norm_calc;
    end
  end

endmodule
